// File: rtl/pad_mux_pkg.sv
// Shared register layout, guard FSM encoding and select saturation for the pad multiplexer.
package pad_mux_pkg;

    localparam int SEL_LSB   = 0;
    localparam int CFG_LSB   = 8;
    localparam int LOCK_BIT  = 30;
    localparam int GUARD_BIT = 31;

    typedef enum logic {
        ACTIVE = 1'b0,
        GUARD  = 1'b1
    } guard_state_e;

    // Clamp an 8-bit select field to the highest implemented alternate.
    function automatic logic [7:0] sat_sel(input logic [7:0] raw, input int n_alt);
        if ({24'b0, raw} >= 32'(n_alt)) begin
            return 8'(n_alt - 1);
        end
        return raw;
    endfunction

endpackage

// File: rtl/pad_mux_guard.sv
// Per-pad switchover guard: blanks the pad for GUARD_CYCLES cycles after each select change.
module pad_mux_guard
    import pad_mux_pkg::*;
#(
    parameter int GUARD_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sel_change_i,
    output logic guard_o
);

    localparam logic [7:0] RELOAD = 8'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    guard_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new select change wins over an expiring window and restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sel_change_i && (GUARD_CYCLES > 0)) begin
            state_d = GUARD;
            cnt_d   = RELOAD;
        end else if (state_q == GUARD) begin
            if (cnt_q == 8'd0) begin
                state_d = ACTIVE;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    assign guard_o = (state_q == GUARD);

endmodule

// File: rtl/pad_mux_ctrl.sv
// Register-programmable pad multiplexer with per-pad lock and switchover blanking.
// Config port: a transfer is accepted on any edge with cfg_req_i=1 (grant is always 1); cfg_rvalid_o pulses the next cycle for reads and writes.
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int   N_PADS       = 48,
    parameter int   N_ALT        = 4,
    parameter int   CFG_W        = 6,
    parameter int   GUARD_CYCLES = 4,
    parameter logic IN_DEFAULT   = 1'b0,
    localparam int  SEL_W        = $clog2(N_ALT),
    localparam int  ADDR_W       = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cfg_req_i,
    input  logic                               cfg_we_i,
    input  logic [ADDR_W-1:0]                  cfg_addr_i,
    input  logic [31:0]                        cfg_wdata_i,
    output logic                               cfg_gnt_o,
    output logic                               cfg_rvalid_o,
    output logic [31:0]                        cfg_rdata_o,
    input  logic [N_ALT-1:0][N_PADS-1:0]       periph_out_i,
    input  logic [N_ALT-1:0][N_PADS-1:0]       periph_oe_i,
    output logic [N_ALT-1:0][N_PADS-1:0]       periph_in_o,
    output logic [N_PADS-1:0]                  pad_out_o,
    output logic [N_PADS-1:0]                  pad_oe_o,
    input  logic [N_PADS-1:0]                  pad_in_i,
    output logic [N_PADS-1:0][CFG_W-1:0]       pad_cfg_o,
    output logic [N_PADS-1:0]                  guard_active_o
);

    logic [N_PADS-1:0][SEL_W-1:0] sel_q, sel_d;
    logic [N_PADS-1:0][CFG_W-1:0] cfg_q, cfg_d;
    logic [N_PADS-1:0]            lock_q, lock_d;
    logic [N_PADS-1:0]            wr_hit, sel_change, guard;
    logic                         rvalid_q;
    logic [31:0]                  rdata_q, rdata_d;
    logic [7:0]                   wr_sel_sat, sel_ext, cfg_ext;
    logic [SEL_W-1:0]             wr_sel;
    logic                         unused_wdata;

    assign wr_sel_sat   = sat_sel(cfg_wdata_i[SEL_LSB +: 8], N_ALT);
    assign wr_sel       = wr_sel_sat[SEL_W-1:0];
    assign unused_wdata = ^{cfg_wdata_i[31], cfg_wdata_i[29:16], cfg_wdata_i[15:8], wr_sel_sat};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q    <= '0;
            cfg_q    <= '0;
            lock_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            sel_q    <= sel_d;
            cfg_q    <= cfg_d;
            lock_q   <= lock_d;
            rvalid_q <= cfg_req_i;
            rdata_q  <= rdata_d;
        end
    end

    // Locked pads never match, which also makes lock set-only until reset.
    always_comb begin
        sel_d      = sel_q;
        cfg_d      = cfg_q;
        lock_d     = lock_q;
        wr_hit     = '0;
        sel_change = '0;
        for (int p = 0; p < N_PADS; p++) begin
            wr_hit[p] = cfg_req_i && cfg_we_i && !lock_q[p] && (cfg_addr_i == ADDR_W'(p));
            if (wr_hit[p]) begin
                sel_change[p] = (wr_sel != sel_q[p]);
                sel_d[p]      = wr_sel;
                cfg_d[p]      = cfg_wdata_i[CFG_LSB +: CFG_W];
                lock_d[p]     = cfg_wdata_i[LOCK_BIT];
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        sel_ext = '0;
        cfg_ext = '0;
        if (cfg_req_i && !cfg_we_i) begin
            for (int p = 0; p < N_PADS; p++) begin
                if (cfg_addr_i == ADDR_W'(p)) begin
                    sel_ext[SEL_W-1:0]     = sel_q[p];
                    cfg_ext[CFG_W-1:0]     = cfg_q[p];
                    rdata_d[SEL_LSB +: 8]  = sel_ext;
                    rdata_d[CFG_LSB +: 8]  = cfg_ext;
                    rdata_d[LOCK_BIT]      = lock_q[p];
                    rdata_d[GUARD_BIT]     = guard[p];
                end
            end
        end
    end

    for (genvar p = 0; p < N_PADS; p++) begin : gen_guard
        pad_mux_guard #(
            .GUARD_CYCLES(GUARD_CYCLES)
        ) u_guard (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .sel_change_i(sel_change[p]),
            .guard_o     (guard[p])
        );
    end

    // Guarded pads are tri-stated and every alternate sees the idle input level.
    always_comb begin
        pad_out_o   = '0;
        pad_oe_o    = '0;
        periph_in_o = {(N_ALT * N_PADS){IN_DEFAULT}};
        for (int p = 0; p < N_PADS; p++) begin
            if (!guard[p]) begin
                pad_out_o[p]             = periph_out_i[sel_q[p]][p];
                pad_oe_o[p]              = periph_oe_i[sel_q[p]][p];
                periph_in_o[sel_q[p]][p] = pad_in_i[p];
            end
        end
    end

    assign cfg_gnt_o      = 1'b1;
    assign cfg_rvalid_o   = rvalid_q;
    assign cfg_rdata_o    = rdata_q;
    assign pad_cfg_o      = cfg_q;
    assign guard_active_o = guard;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Directed bench for pad_mux_ctrl: config responses go through an expected queue, pad outputs are checked at sample points.
module tb_pad_mux_ctrl;

  localparam int N_PADS = 48;
  localparam int N_ALT = 4;
  localparam int CFG_W = 6;
  localparam int GUARD_CYCLES = 4;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_req = 1'b0;
  logic cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic cfg_gnt;
  logic cfg_rvalid;
  logic [31:0] cfg_rdata;
  logic [N_ALT-1:0][N_PADS-1:0] periph_out = '0;
  logic [N_ALT-1:0][N_PADS-1:0] periph_oe = '0;
  logic [N_ALT-1:0][N_PADS-1:0] periph_in;
  logic [N_PADS-1:0] pad_out;
  logic [N_PADS-1:0] pad_oe;
  logic [N_PADS-1:0] pad_in = '0;
  logic [N_PADS-1:0][CFG_W-1:0] pad_cfg;
  logic [N_PADS-1:0] guard_active;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  bit chk_q[$];
  string name_q[$];

  pad_mux_ctrl #(
    .N_PADS(N_PADS),
    .N_ALT(N_ALT),
    .CFG_W(CFG_W),
    .GUARD_CYCLES(GUARD_CYCLES),
    .IN_DEFAULT(1'b0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cfg_req_i(cfg_req),
    .cfg_we_i(cfg_we),
    .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata),
    .cfg_gnt_o(cfg_gnt),
    .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o(cfg_rdata),
    .periph_out_i(periph_out),
    .periph_oe_i(periph_oe),
    .periph_in_o(periph_in),
    .pad_out_o(pad_out),
    .pad_oe_o(pad_oe),
    .pad_in_i(pad_in),
    .pad_cfg_o(pad_cfg),
    .guard_active_o(guard_active)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: called just after a rising edge, return just after the accepting edge
  task automatic cfg_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input string name);
    exp_q.push_back(32'h0);
    chk_q.push_back(1'b0);
    name_q.push_back(name);
    cfg_req = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    cfg_req = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    chk_q.push_back(1'b1);
    name_q.push_back(name);
    cfg_req = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = addr;
    cfg_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    cfg_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: one response per rvalid, sampled on the falling edge
  always @(negedge clk) begin
    logic [31:0] e;
    bit c;
    string n;
    if (cfg_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got rvalid=1 expected no response pending");
      end else begin
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        n = name_q.pop_front();
        if (c) check({"rdata_", n}, 64'(cfg_rdata), 64'(e));
      end
    end
  end

  initial begin
    // reset
    idle(2);
    @(negedge clk);
    check("rst_rvalid", 64'(cfg_rvalid), 64'h0);
    check("rst_rdata", 64'(cfg_rdata), 64'h0);
    check("rst_guard", 64'(guard_active), 64'h0);
    check("gnt", 64'(cfg_gnt), 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    cfg_read(6'd0, 32'h0, "rst_pad0");
    cfg_read(6'd5, 32'h0, "rst_pad5");
    cfg_read(6'd47, 32'h0, "rst_pad47");

    // all pads follow alternate 0 out of reset
    periph_out[0] = '1;
    periph_oe[0] = '1;
    pad_in = 48'hA5C3_0F1E_9B27;
    @(negedge clk);
    check("alt0_out", 64'(pad_out), 64'hFFFF_FFFF_FFFF);
    check("alt0_oe", 64'(pad_oe), 64'hFFFF_FFFF_FFFF);
    check("alt0_in0", 64'(periph_in[0]), 64'hA5C3_0F1E_9B27);
    check("alt0_in1", 64'(periph_in[1]), 64'h0);
    check("alt0_in3", 64'(periph_in[3]), 64'h0);
    @(posedge clk);
    #1;

    // switchover pad 5 to alt 2
    periph_out[2][5] = 1'b1;
    periph_oe[2][5] = 1'b1;
    pad_in[5] = 1'b1;
    cfg_write(6'd5, 32'h0000_0002, "sw_wr");
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("sw_guard_t%0d", k), 64'(guard_active[5]), 64'h1);
      check($sformatf("sw_oe_t%0d", k), 64'(pad_oe[5]), 64'h0);
      check($sformatf("sw_out_t%0d", k), 64'(pad_out[5]), 64'h0);
      check($sformatf("sw_in2_t%0d", k), 64'(periph_in[2][5]), 64'h0);
    end
    check("sw_others", 64'(guard_active & ~(48'h1 << 5)), 64'h0);
    @(negedge clk);
    check("sw_guard_t5", 64'(guard_active[5]), 64'h0);
    check("sw_oe_t5", 64'(pad_oe[5]), 64'h1);
    check("sw_in2_t5", 64'(periph_in[2][5]), 64'h1);
    check("sw_in0_t5", 64'(periph_in[0][5]), 64'h0);
    pad_in[5] = 1'b0;
    #1;
    check("sw_in2_track", 64'(periph_in[2][5]), 64'h0);
    @(posedge clk);
    #1;
    cfg_read(6'd5, 32'h0000_0002, "sw_rd");

    // restart: sel 1 at T, sel 3 at T+2
    periph_oe[1][5] = 1'b0;
    periph_out[3][5] = 1'b1;
    periph_oe[3][5] = 1'b1;
    cfg_write(6'd5, 32'h0000_0001, "rs_wr1");
    @(negedge clk);
    check("rs_guard_t1", 64'(guard_active[5]), 64'h1);
    @(posedge clk);
    #1;
    cfg_write(6'd5, 32'h0000_0003, "rs_wr2");
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("rs_guard_t%0d", k), 64'(guard_active[5]), 64'h1);
    end
    @(negedge clk);
    check("rs_guard_t7", 64'(guard_active[5]), 64'h0);
    check("rs_oe_t7", 64'(pad_oe[5]), 64'h1);
    check("rs_out_t7", 64'(pad_out[5]), 64'h1);
    @(posedge clk);
    #1;

    // lock pad 7
    cfg_write(6'd7, 32'h4000_0301, "lk_wr1");
    cfg_write(6'd7, 32'h0000_0000, "lk_wr2");
    idle(4);
    cfg_read(6'd7, 32'h4000_0301, "lk_rd");
    @(negedge clk);
    check("lk_cfg", 64'(pad_cfg[7]), 64'h3);
    @(posedge clk);
    #1;

    // select saturation
    cfg_write(6'd9, 32'h0000_00FF, "sat_wr");
    idle(4);
    cfg_read(6'd9, 32'h0000_0003, "sat_rd");

    // out-of-range address
    cfg_write(6'd48, 32'h0000_0001, "oob_wr");
    cfg_read(6'd48, 32'h0, "oob_rd48");
    @(negedge clk);
    check("oob_rvalid", 64'(cfg_rvalid), 64'h1);
    @(posedge clk);
    #1;
    cfg_read(6'd63, 32'h0, "oob_rd63");
    cfg_read(6'd0, 32'h0, "oob_pad0");

    // cfg-only write, sel unchanged
    cfg_write(6'd9, 32'h0000_2A03, "cfg_wr");
    @(negedge clk);
    check("cfg_guard_t1", 64'(guard_active[9]), 64'h0);
    check("cfg_val_t1", 64'(pad_cfg[9]), 64'h2A);
    @(posedge clk);
    #1;
    cfg_read(6'd9, 32'h0000_2A03, "cfg_rd");

    // reset in the middle of a switchover on pad 11
    cfg_write(6'd11, 32'h0000_0002, "mr_wr");
    idle(1);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_guard", 64'(guard_active[11]), 64'h0);
    check("mr_oe", 64'(pad_oe[11]), 64'h1);
    check("mr_out", 64'(pad_out[11]), 64'h1);
    check("mr_rvalid", 64'(cfg_rvalid), 64'h0);
    @(posedge clk);
    #1;
    // anything still queued belonged to transfers cancelled by the reset
    exp_q.delete();
    chk_q.delete();
    name_q.delete();
    cfg_read(6'd11, 32'h0, "mr_rd11");
    cfg_read(6'd7, 32'h0, "mr_rd7");

    idle(3);
    check("resp_drain", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
